// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit with HI/LO registers and mthi/mtlo writes.
// Optional feature macro: MDU_CANCEL_EN adds a `cancel` flush input.
module mdu_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mdu_op,
`ifdef MDU_CANCEL_EN
  input  logic             cancel,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0]    MUL_LD = CW'(MUL_CYCLES);
  localparam logic [CW-1:0]    DIV_LD = CW'(DIV_CYCLES);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_r, state_n;
  logic [CW-1:0]    cnt_r, cnt_n;
  logic [2:0]       op_r, op_n;
  logic [WIDTH-1:0] a_r, a_n, b_r, b_n;
  logic [WIDTH-1:0] hi_r, hi_n, lo_r, lo_n;
  logic             busy_r, busy_n;
  logic             cancel_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] res_hi_s, res_lo_s;

`ifdef MDU_CANCEL_EN
  assign cancel_s = cancel;
`else
  assign cancel_s = 1'b0;
`endif

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  // Result from latched operands; divide by zero leaves HI/LO as they are.
  always_comb begin
    prod_s   = '0;
    res_hi_s = hi_r;
    res_lo_s = lo_r;
    case (op_r)
      OP_MULT: begin
        prod_s = $signed({{WIDTH{a_r[WIDTH-1]}}, a_r}) * $signed({{WIDTH{b_r[WIDTH-1]}}, b_r});
        {res_hi_s, res_lo_s} = prod_s;
      end
      OP_MULTU: begin
        prod_s = {{WIDTH{1'b0}}, a_r} * {{WIDTH{1'b0}}, b_r};
        {res_hi_s, res_lo_s} = prod_s;
      end
      OP_DIV: begin
        if (b_r == '0) begin
          res_hi_s = hi_r;
        end else if ((a_r == SMIN) && (b_r == '1)) begin
          res_lo_s = SMIN;
          res_hi_s = '0;
        end else begin
          res_lo_s = $signed(a_r) / $signed(b_r);
          res_hi_s = $signed(a_r) % $signed(b_r);
        end
      end
      OP_DIVU: begin
        if (b_r == '0) begin
          res_hi_s = hi_r;
        end else begin
          res_lo_s = a_r / b_r;
          res_hi_s = a_r % b_r;
        end
      end
      default: begin
        res_hi_s = hi_r;
      end
    endcase
  end

  // Next-state: accept in IDLE, count down in RUN, retire on the 1->0 step.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    op_n    = op_r;
    a_n     = a_r;
    b_n     = b_r;
    hi_n    = hi_r;
    lo_n    = lo_r;
    busy_n  = busy_r;
    case (state_r)
      IDLE: begin
        if (start && !cancel_s) begin
          case (mdu_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              op_n    = mdu_op;
              a_n     = A;
              b_n     = B;
              cnt_n   = ((mdu_op == OP_MULT) || (mdu_op == OP_MULTU)) ? MUL_LD : DIV_LD;
              state_n = RUN;
              busy_n  = 1'b1;
            end
            OP_MTHI: hi_n = A;
            OP_MTLO: lo_n = A;
            default: state_n = IDLE;
          endcase
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (cancel_s) begin
          cnt_n   = '0;
          state_n = IDLE;
          busy_n  = 1'b0;
        end else if (cnt_r == CNT_ONE) begin
          cnt_n   = '0;
          hi_n    = res_hi_s;
          lo_n    = res_lo_s;
          state_n = IDLE;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      op_r    <= 3'd0;
      a_r     <= '0;
      b_r     <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      op_r    <= op_n;
      a_r     <= a_n;
      b_r     <= b_n;
      hi_r    <= hi_n;
      lo_r    <= lo_n;
      busy_r  <= busy_n;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases plus randomized ops against
// an arithmetic reference model.
module tb_mdu_iter;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  mdu_op;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif
  logic [31:0] A, B, hi, lo;
  logic        busy;
  int          checks = 0, failures = 0;
  logic [31:0] exp_hi = 32'd0, exp_lo = 32'd0;

  always #5 clk = ~clk;

  mdu_iter dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
`ifdef MDU_CANCEL_EN
    .cancel(cancel),
`endif
    .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return 5;
    else if (op == 3'd3 || op == 3'd4) return 10;
    else return 0;
  endfunction

  // Architectural effect of one accepted op on HI/LO.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    longint unsigned ua, ub, pu;
    int si, sj;
    case (op)
      3'd1: begin sa = $signed(a); sb = $signed(b); p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'd2: begin ua = a; ub = b; pu = ua * ub; exp_hi = pu[63:32]; exp_lo = pu[31:0]; end
      3'd3: if (b != 32'd0) begin
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin exp_lo = a; exp_hi = 32'd0; end
        else begin si = a; sj = b; exp_lo = si / sj; exp_hi = si % sj; end
      end
      3'd4: if (b != 32'd0) begin exp_lo = a / b; exp_hi = a % b; end
      3'd5: exp_hi = a;
      3'd6: exp_lo = a;
      default: ;
    endcase
  endtask

  // Issue one op, scramble inputs (including start) while busy, check latency and result.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n;
    int lat;
    logic [31:0] h0, l0;
    lat = lat_of(op); h0 = exp_hi; l0 = exp_lo;
    @(negedge clk); start = 1'b1; mdu_op = op; A = a; B = b;
    @(negedge clk); start = 1'b0; A = $urandom; B = $urandom; mdu_op = 3'($urandom_range(0, 7));
    model(op, a, b);
    if (lat == 0) begin
      check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    end else begin
      n = 0;
      while (busy === 1'b1 && n < 200) begin
        if (n == 0) begin
          check({tag, "_hold_hi"}, {32'd0, hi}, {32'd0, h0});
          check({tag, "_hold_lo"}, {32'd0, lo}, {32'd0, l0});
        end
        n++;
        start = 1'($urandom_range(0, 1)); mdu_op = 3'($urandom_range(0, 7));
        A = $urandom; B = $urandom;
        @(negedge clk);
      end
      start = 1'b0;
      check({tag, "_lat"}, 64'(n), 64'(lat));
    end
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    reset = 1'b1; start = 1'b0; mdu_op = 3'd0; A = 32'd0; B = 32'd0;
`ifdef MDU_CANCEL_EN
    cancel = 1'b0;
`endif
    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk); reset = 1'b0;

    issue(3'd1, 32'hFFFFFFFF, 32'h00000002, "mult");
    check("mult_hi_const", {32'd0, hi}, 64'hFFFFFFFF);
    issue(3'd2, 32'hFFFFFFFF, 32'h00000002, "multu");
    check("multu_hi_const", {32'd0, hi}, 64'h00000001);
    issue(3'd3, 32'hFFFFFFF9, 32'h00000002, "div_neg");
    check("div_lo_const", {32'd0, lo}, 64'hFFFFFFFD);
    issue(3'd4, 32'd100, 32'd7, "divu");
    check("divu_lo_const", {32'd0, lo}, 64'd14);

    // mthi then mtlo on consecutive edges
    @(negedge clk); start = 1'b1; mdu_op = 3'd5; A = 32'h12345678;
    @(negedge clk); mdu_op = 3'd6; A = 32'h9ABCDEF0;
    check("mthi_hi", {32'd0, hi}, 64'h12345678);
    check("mthi_busy", {63'd0, busy}, 64'd0);
    @(negedge clk); start = 1'b0;
    check("mtlo_lo", {32'd0, lo}, 64'h9ABCDEF0);
    check("mtlo_busy", {63'd0, busy}, 64'd0);
    exp_hi = 32'h12345678; exp_lo = 32'h9ABCDEF0;

    issue(3'd5, 32'hAAAA0000, 32'd0, "pre_hi");
    issue(3'd6, 32'h0000BBBB, 32'd0, "pre_lo");
    issue(3'd3, 32'h00001234, 32'd0, "div0");
    check("div0_hi_const", {32'd0, hi}, 64'hAAAA0000);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    check("div_ovf_lo_const", {32'd0, lo}, 64'h80000000);

    // back-to-back: divu held on start as multu retires
    @(negedge clk); start = 1'b1; mdu_op = 3'd2; A = 32'd3; B = 32'd4;
    @(negedge clk); mdu_op = 3'd4; A = 32'd9; B = 32'd2;
    n = 0;
    while (busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
    check("b2b_mul_lat", 64'(n), 64'd5);
    check("b2b_mul_hi", {32'd0, hi}, 64'd0);
    check("b2b_mul_lo", {32'd0, lo}, 64'd12);
    @(negedge clk);
    check("b2b_accept", {63'd0, busy}, 64'd1);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
    check("b2b_div_lat", 64'(n), 64'd10);
    check("b2b_div_hi", {32'd0, hi}, 64'd1);
    check("b2b_div_lo", {32'd0, lo}, 64'd4);
    exp_hi = 32'd1; exp_lo = 32'd4;

`ifdef MDU_CANCEL_EN
    @(negedge clk); start = 1'b1; mdu_op = 3'd1; A = 32'd77; B = 32'd99;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    check("cancel_busy", {63'd0, busy}, 64'd0);
    check("cancel_hi", {32'd0, hi}, {32'd0, exp_hi});
    check("cancel_lo", {32'd0, lo}, {32'd0, exp_lo});
    @(negedge clk); start = 1'b1; cancel = 1'b1; mdu_op = 3'd5; A = 32'hCAFEF00D;
    @(negedge clk); start = 1'b0; cancel = 1'b0;
    check("cancel_idle_hi", {32'd0, hi}, {32'd0, exp_hi});
`endif

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: begin ra = 32'($urandom_range(0, 200)) - 32'd100; rb = 32'($urandom_range(1, 20)) - 32'd10; end
        default: ;
      endcase
      issue(rop, ra, rb, "rand");
    end

    // asynchronous reset in the middle of a mult
    issue(3'd5, 32'hDEAD0001, 32'd0, "pre_rst");
    @(negedge clk); start = 1'b1; mdu_op = 3'd1; A = 32'd3; B = 32'd5;
    @(negedge clk); start = 1'b0;
    @(negedge clk); #2 reset = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_hi", {32'd0, hi}, 64'd0);
    check("arst_lo", {32'd0, lo}, 64'd0);
    exp_hi = 32'd0; exp_lo = 32'd0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); @(negedge clk);
    check("arst_idle_busy", {63'd0, busy}, 64'd0);
    check("arst_idle_hi", {32'd0, hi}, 64'd0);
    issue(3'd2, 32'd6, 32'd7, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
